sram_arb_ctrl: RTL and testbench
================================

Name: sram_arb_ctrl

Overview:
Two-requester round-robin arbiter and sequencer for the single-port synchronous SRAM macro (ADDR/DATA parameterised, registered read data, 1-cycle read latency).
After reset, and on demand, it zero-fills the whole array with a hardware sweep. It then grants at most one access per cycle and returns read data to the requester that issued the read.
It sits between the SRAM and its two client blocks, A and B, and is the only driver of the SRAM control pins.

Parameters:
ADDR, 4, SRAM address width; the array depth is 2**ADDR.
DATA, 8, SRAM data width.

Ports:
clk  in  1  clock; all logic is on the rising edge.
wrst_n  in  1  reset, synchronous, active-low.
clr_req  in  1  single-cycle pulse; requests a re-run of the zero-fill sweep.
init_done  out  1  high when the controller is in RUN.
a_valid  in  1  requester A has a request.
a_we  in  1  A request type: 1 = write, 0 = read.
a_addr  in  ADDR  A address.
a_wdata  in  DATA  A write data.
a_ready  out  1  A request accepted this cycle.
a_rsp_valid  out  1  A read data valid.
a_rsp_data  out  DATA  A read data.
b_valid, b_we, b_addr, b_wdata, b_ready, b_rsp_valid, b_rsp_data  same as A, for requester B.
sram_chip_en  out  1  SRAM chip enable.
sram_wr_en  out  1  SRAM write enable.
sram_op_en  out  1  SRAM read enable.
sram_address  out  ADDR  SRAM address.
sram_write_data  out  DATA  SRAM write data.
sram_rrst_n  out  1  SRAM read-side reset; equals wrst_n.
sram_read_data  in  DATA  SRAM registered read data.

Behaviour:
- States: INIT and RUN. Reset value is INIT.
- Reset values: sweep counter 0, init_done 0, a/b_rsp_valid 0, round-robin pointer = A, pending-clear flag 0.
- wrst_n low at any time, including mid-sweep or mid-read, returns the block to INIT with counter 0. Any in-flight rsp_valid is dropped.
- INIT:
  - Each cycle drives sram_chip_en=1, sram_wr_en=1, sram_op_en=0, sram_address=counter, sram_write_data=0.
  - Counter increments every cycle. When counter = 2**ADDR-1, that write is issued and the next state is RUN.
  - The sweep therefore takes exactly 2**ADDR cycles. a_ready and b_ready are 0 throughout.
- RUN:
  - init_done=1.
  - Grant logic is combinational from the valids and the pointer:
    - If only one valid is high, that requester wins.
    - If both are high, the requester named by the pointer wins.
  - After any grant, the pointer moves to the other requester. With no grant, the pointer holds.
  - The winner's ready is asserted in the same cycle; a transfer occurs when valid && ready.
  - The SRAM pins carry the granted request in that same cycle: chip_en=1, wr_en=we, op_en=~we, address and write_data from the winner.
  - With no grant: chip_en, wr_en and op_en are 0. Address and write data are don't-care; drive 0.
  - Requesters hold valid and payload stable until ready is seen.
- Read return:
  - For a read granted at cycle N, x_rsp_valid=1 in cycle N+1 only.
  - x_rsp_data passes sram_read_data through combinationally.
  - The rsp_data value is only meaningful while rsp_valid is high.
- Back-to-back traffic:
  - Reads can issue every cycle. Responses arrive in order, one per cycle.
  - A write followed by a read of the same address on the next cycle returns the new data; the SRAM write has completed at the edge.
- clr_req:
  - In RUN, the pulse sets the pending-clear flag.
  - At the next cycle edge the block enters INIT with counter 0 and clears the flag.
  - The cycle in which clr_req is sampled may still grant normally.
  - The read response for a read granted in that cycle is still delivered in cycle N+1 during INIT.
  - clr_req during INIT is ignored.

Decomposition:
- Package sram_ctrl_pkg: state enum (INIT, RUN), requester index typedef (REQ_A, REQ_B), default ADDR/DATA constants.
- One natural sub-module, rr_arb2: 2-way round-robin grant logic plus the pointer flop. Its interface is req[1:0], gnt[1:0] one-hot, and an advance input.
- FSM, sweep counter and response tracking stay in the top module.

Test Plan:
- Reset then idle → sram_wr_en=1 for exactly 16 cycles with addresses 0..15 and data 0x00; init_done rises on cycle 17; no ready seen during the sweep.
- A writes 0x5A to addr 3, then A reads addr 3 on the next cycle → a_rsp_valid pulses one cycle later with a_rsp_data=0x5A; b_rsp_valid stays 0.
- A and B both hold valid reads (addr 1 and 2) for 4 cycles with the pointer at A → grant order A, B, A, B; responses alternate a_rsp, b_rsp in order.
- Only B valid for 3 cycles, then both valid → B granted 3 times; the next contested cycle grants A, since the pointer was moved to A by B's last grant.
- Write 0xFF to all 16 addresses, pulse clr_req, wait for init_done, read addr 7 → 0x00.
- Assert wrst_n low at sweep counter 9, hold 1 cycle, release → sweep restarts at address 0 and takes a full 16 cycles; no rsp_valid pulse occurs.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizing for the SRAM arbiter/sequencer.
package sram_ctrl_pkg;

    localparam int ADDR_DEF = 4;
    localparam int DATA_DEF = 8;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_idx_e;

endpackage

// File: rtl/sram_arb_ctrl_rr_arb2.sv
// Two-way round-robin grant: pointer names the winner when both requesters are valid.
module rr_arb2
    import sram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       wrst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    req_idx_e ptr_r;

    // One-hot grant from requests and pointer
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (ptr_r == REQ_A) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // Pointer moves to the requester that did not just win
    always_ff @(posedge clk) begin
        if (!wrst_n) begin
            ptr_r <= REQ_A;
        end else if (advance) begin
            ptr_r <= gnt[0] ? REQ_B : REQ_A;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Zero-fill sequencer and two-client round-robin front end for a single-port SRAM.
module sram_arb_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR = ADDR_DEF,
    parameter int DATA = DATA_DEF
) (
    input  logic            clk,
    input  logic            wrst_n,
    input  logic            clr_req,
    output logic            init_done,
    input  logic            a_valid,
    input  logic            a_we,
    input  logic [ADDR-1:0] a_addr,
    input  logic [DATA-1:0] a_wdata,
    output logic            a_ready,
    output logic            a_rsp_valid,
    output logic [DATA-1:0] a_rsp_data,
    input  logic            b_valid,
    input  logic            b_we,
    input  logic [ADDR-1:0] b_addr,
    input  logic [DATA-1:0] b_wdata,
    output logic            b_ready,
    output logic            b_rsp_valid,
    output logic [DATA-1:0] b_rsp_data,
    output logic            sram_chip_en,
    output logic            sram_wr_en,
    output logic            sram_op_en,
    output logic [ADDR-1:0] sram_address,
    output logic [DATA-1:0] sram_write_data,
    output logic            sram_rrst_n,
    input  logic [DATA-1:0] sram_read_data
);

    state_e          state_r;
    logic [ADDR-1:0] cnt_r;
    logic            init_done_r;
    logic            rd_a_r;
    logic            rd_b_r;
    logic [1:0]      req_s;
    logic [1:0]      gnt_s;

    // Requests are only visible to the arbiter once the sweep is finished
    always_comb begin
        req_s = 2'b00;
        if (state_r == RUN) begin
            req_s = {b_valid, a_valid};
        end else begin
            req_s = 2'b00;
        end
    end

    rr_arb2 u_arb (
        .clk     (clk),
        .wrst_n  (wrst_n),
        .req     (req_s),
        .advance (|gnt_s),
        .gnt     (gnt_s)
    );

    // SRAM pin mux: sweep write in INIT, granted request in RUN
    always_comb begin
        sram_chip_en    = 1'b0;
        sram_wr_en      = 1'b0;
        sram_op_en      = 1'b0;
        sram_address    = {ADDR{1'b0}};
        sram_write_data = {DATA{1'b0}};
        case (state_r)
            INIT: begin
                sram_chip_en = 1'b1;
                sram_wr_en   = 1'b1;
                sram_address = cnt_r;
            end
            RUN: begin
                if (gnt_s[0]) begin
                    sram_chip_en    = 1'b1;
                    sram_wr_en      = a_we;
                    sram_op_en      = ~a_we;
                    sram_address    = a_addr;
                    sram_write_data = a_wdata;
                end else if (gnt_s[1]) begin
                    sram_chip_en    = 1'b1;
                    sram_wr_en      = b_we;
                    sram_op_en      = ~b_we;
                    sram_address    = b_addr;
                    sram_write_data = b_wdata;
                end else begin
                    sram_chip_en = 1'b0;
                end
            end
            default: begin
                sram_chip_en = 1'b0;
            end
        endcase
    end

    // Sequencer state, sweep counter and read-return tracking
    always_ff @(posedge clk) begin
        if (!wrst_n) begin
            state_r     <= INIT;
            cnt_r       <= {ADDR{1'b0}};
            init_done_r <= 1'b0;
            rd_a_r      <= 1'b0;
            rd_b_r      <= 1'b0;
        end else begin
            rd_a_r <= gnt_s[0] & ~a_we;
            rd_b_r <= gnt_s[1] & ~b_we;
            case (state_r)
                INIT: begin
                    cnt_r <= cnt_r + ADDR'(1'b1);
                    if (cnt_r == {ADDR{1'b1}}) begin
                        state_r     <= RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        state_r     <= INIT;
                        init_done_r <= 1'b0;
                    end
                end
                RUN: begin
                    // The clear takes effect at the very edge that samples it
                    if (clr_req) begin
                        state_r     <= INIT;
                        cnt_r       <= {ADDR{1'b0}};
                        init_done_r <= 1'b0;
                    end else begin
                        state_r     <= RUN;
                        init_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= INIT;
                    cnt_r       <= {ADDR{1'b0}};
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign init_done   = init_done_r;
    assign a_ready     = gnt_s[0];
    assign b_ready     = gnt_s[1];
    assign a_rsp_valid = rd_a_r;
    assign b_rsp_valid = rd_b_r;
    assign a_rsp_data  = sram_read_data;
    assign b_rsp_data  = sram_read_data;
    assign sram_rrst_n = wrst_n;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed bench for sram_arb_ctrl with a behavioural SRAM model.
module tb_sram_arb_ctrl;

    logic       clk = 1'b0;
    logic       wrst_n, clr_req, init_done;
    logic       a_valid, a_we, a_ready, a_rsp_valid;
    logic [3:0] a_addr;
    logic [7:0] a_wdata, a_rsp_data;
    logic       b_valid, b_we, b_ready, b_rsp_valid;
    logic [3:0] b_addr;
    logic [7:0] b_wdata, b_rsp_data;
    logic       sram_chip_en, sram_wr_en, sram_op_en, sram_rrst_n;
    logic [3:0] sram_address;
    logic [7:0] sram_write_data, sram_read_data;
    logic [7:0] mem [16];

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    sram_arb_ctrl #(.ADDR(4), .DATA(8)) dut (
        .clk(clk), .wrst_n(wrst_n), .clr_req(clr_req), .init_done(init_done),
        .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
        .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
        .sram_chip_en(sram_chip_en), .sram_wr_en(sram_wr_en), .sram_op_en(sram_op_en),
        .sram_address(sram_address), .sram_write_data(sram_write_data),
        .sram_rrst_n(sram_rrst_n), .sram_read_data(sram_read_data)
    );

    // Single-port SRAM with registered read data
    always @(posedge clk) begin
        if (sram_chip_en) begin
            if (sram_wr_en) mem[sram_address] <= sram_write_data;
            else if (sram_op_en) sram_read_data <= mem[sram_address];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        wrst_n = 1'b0; clr_req = 1'b0;
        a_valid = 1'b0; a_we = 1'b0; a_addr = 4'd0; a_wdata = 8'h00;
        b_valid = 1'b0; b_we = 1'b0; b_addr = 4'd0; b_wdata = 8'h00;
        tick; tick;
        #1;
        chk("rst_init_done", init_done, 0);
        chk("rst_a_rsp", a_rsp_valid, 0);
        chk("rst_b_rsp", b_rsp_valid, 0);
        chk("rst_rrst", sram_rrst_n, 0);

        // Power-on sweep with both requesters pushing
        wrst_n = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("sw_we", sram_wr_en, 1);
            chk("sw_addr", sram_address, i);
            chk("sw_data", sram_write_data, 0);
            chk("sw_rdy", {a_ready, b_ready}, 0);
            chk("sw_done", init_done, 0);
            if (i == 15) begin
                a_valid = 1'b0; b_valid = 1'b0;
            end
            tick;
        end
        #1;
        chk("run_done", init_done, 1);
        chk("idle_ce", sram_chip_en, 0);

        // A writes 0x5A to addr 3, then reads it back
        a_valid = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 8'h5A;
        #1;
        chk("w_ardy", a_ready, 1);
        chk("w_pins", {sram_wr_en, sram_op_en, sram_address, sram_write_data}, {2'b10, 4'd3, 8'h5A});
        tick;
        a_we = 1'b0;
        #1;
        chk("r_pins", {a_ready, sram_wr_en, sram_op_en}, 3'b101);
        tick;
        a_valid = 1'b0;
        #1;
        chk("r_a_rsp_v", a_rsp_valid, 1);
        chk("r_a_rsp_d", a_rsp_data, 8'h5A);
        chk("r_b_rsp_v", b_rsp_valid, 0);
        tick;
        chk("r_a_rsp_once", a_rsp_valid, 0);

        // Seed addr1/addr2; B's grant leaves the pointer at A
        a_valid = 1'b1; a_we = 1'b1; a_addr = 4'd1; a_wdata = 8'h11;
        #1 chk("s_a", a_ready, 1);
        tick;
        a_valid = 1'b0; b_valid = 1'b1; b_we = 1'b1; b_addr = 4'd2; b_wdata = 8'h22;
        #1 chk("s_b", b_ready, 1);
        tick;

        // Contested reads alternate A,B,A,B
        a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd1;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 4'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("c_gnt", {b_ready, a_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("c_addr", sram_address, (i % 2 == 0) ? 4'd1 : 4'd2);
            if (i > 0) begin
                chk("c_rsp_v", {b_rsp_valid, a_rsp_valid}, (i % 2 == 1) ? 2'b01 : 2'b10);
                chk("c_rsp_d", (i % 2 == 1) ? a_rsp_data : b_rsp_data, (i % 2 == 1) ? 8'h11 : 8'h22);
            end
            tick;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("c_last_rsp", {b_rsp_valid, a_rsp_valid}, 2'b10);
        chk("c_last_d", b_rsp_data, 8'h22);

        // B alone three times, then contest goes to A
        b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bo_gnt", {b_ready, a_ready}, 2'b10);
            tick;
        end
        a_valid = 1'b1;
        #1;
        chk("bo_contest", {b_ready, a_ready}, 2'b01);
        chk("bo_addr", sram_address, 1);
        tick;
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("bo_rsp_v", {b_rsp_valid, a_rsp_valid}, 2'b01);
        chk("bo_rsp_d", a_rsp_data, 8'h11);

        // Fill with 0xFF, then clear while a read is granted
        a_valid = 1'b1; a_we = 1'b1; a_wdata = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            a_addr = 4'(i);
            #1 chk("f_rdy", a_ready, 1);
            tick;
        end
        a_we = 1'b0; a_addr = 4'd5; clr_req = 1'b1;
        #1 chk("clr_cycle_gnt", a_ready, 1);
        tick;
        clr_req = 1'b0; a_valid = 1'b0;
        #1;
        chk("clr_rsp_v", a_rsp_valid, 1);
        chk("clr_rsp_d", a_rsp_data, 8'hFF);
        chk("clr_done", init_done, 0);
        chk("clr_sweep0", {sram_wr_en, sram_address}, 5'b1_0000);
        n = 0;
        while (!init_done && n < 40) begin
            clr_req = (n == 5) ? 1'b1 : 1'b0;
            tick;
            n++;
        end
        clr_req = 1'b0;
        chk("clr_len", n, 16);
        a_valid = 1'b1; a_addr = 4'd7;
        #1 chk("z_rdy", a_ready, 1);
        tick;
        a_valid = 1'b0;
        #1;
        chk("z_rsp_v", a_rsp_valid, 1);
        chk("z_rsp_d", a_rsp_data, 8'h00);

        // Reset on top of a granted read, then again at sweep count 9
        a_valid = 1'b1; wrst_n = 1'b0;
        tick;
        a_valid = 1'b0; wrst_n = 1'b1;
        #1;
        chk("rr_rsp", a_rsp_valid, 0);
        chk("rr_done", init_done, 0);
        repeat (9) tick;
        chk("rr_cnt9", sram_address, 9);
        wrst_n = 1'b0;
        tick;
        wrst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("rr_sweep", {sram_wr_en, sram_address}, {1'b1, 4'(i)});
            chk("rr_norsp", {a_rsp_valid, b_rsp_valid, init_done}, 3'b000);
            tick;
        end
        #1 chk("rr_done2", init_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
